// File: rtl/ps_pcstk_ctrl.sv
// Program-counter stack controller: push/pop/top-of-stack write with sticky overflow/underflow status.
// Optional macro PS_STK_TRAP_EN adds a one-cycle error trap pulse on every rejected push or pop.
module ps_pcstk_ctrl #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned STK_DEPTH = 8,
  parameter int unsigned LVL_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_pshstck,
  input  logic                ps_popstck,
  input  logic [PC_WIDTH-1:0] ps_pc,
  input  logic                ps_tos_wrt_en,
  input  logic [PC_WIDTH-1:0] ps_tos_wrt_data,
  input  logic                ps_stkclr,
  output logic [PC_WIDTH-1:0] ps_tos,
  output logic [LVL_W-1:0]    ps_stk_lvl,
  output logic                ps_stk_empty,
  output logic                ps_stk_full,
  output logic                ps_stk_ovf,
  output logic                ps_stk_unf,
  output logic                ps_pop_vld,
  output logic                ps_stk_trap
);

  localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STK_DEPTH);

  logic [PC_WIDTH-1:0] mem [STK_DEPTH];
  logic [LVL_W-1:0]    lvl;
  logic                ovf_q;
  logic                unf_q;
  logic                pop_vld_q;

  logic                empty_c;
  logic                full_c;
  logic [IDX_W-1:0]    top_idx;
  logic [IDX_W-1:0]    push_idx;

  logic                lvl_inc;
  logic                lvl_dec;
  logic                pop_ack;
  logic                ovf_evt;
  logic                unf_evt;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [PC_WIDTH-1:0] wr_data;

  assign empty_c  = (lvl == '0);
  assign full_c   = (lvl == FULL_LVL);
  assign top_idx  = IDX_W'(lvl - LVL_W'(1));
  assign push_idx = IDX_W'(lvl);

  // Request arbitration: push/pop take priority over the ureg top-of-stack write
  always_comb begin
    lvl_inc = 1'b0;
    lvl_dec = 1'b0;
    pop_ack = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    wr_en   = 1'b0;
    wr_addr = top_idx;
    wr_data = ps_pc;
    if (ps_pshstck && ps_popstck) begin
      wr_en = 1'b1;
      if (empty_c) begin
        lvl_inc = 1'b1;
        wr_addr = push_idx;
      end else begin
        pop_ack = 1'b1;
      end
    end else if (ps_pshstck) begin
      if (full_c) begin
        ovf_evt = 1'b1;
      end else begin
        lvl_inc = 1'b1;
        wr_en   = 1'b1;
        wr_addr = push_idx;
      end
    end else if (ps_popstck) begin
      if (empty_c) begin
        unf_evt = 1'b1;
      end else begin
        lvl_dec = 1'b1;
        pop_ack = 1'b1;
      end
    end else if (ps_tos_wrt_en && !empty_c) begin
      wr_en   = 1'b1;
      wr_data = ps_tos_wrt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      pop_vld_q <= 1'b0;
    end else begin
      if (lvl_inc) begin
        lvl <= lvl + LVL_W'(1);
      end else if (lvl_dec) begin
        lvl <= lvl - LVL_W'(1);
      end
      // Set wins over a coincident clear
      ovf_q     <= ovf_evt | (ovf_q & ~ps_stkclr);
      unf_q     <= unf_evt | (unf_q & ~ps_stkclr);
      pop_vld_q <= pop_ack;
    end
  end

  // Entry storage is not reset; only the level decides what is valid
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef PS_STK_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= ovf_evt | unf_evt;
    end
  end

  assign ps_stk_trap = trap_q;
`else
  assign ps_stk_trap = 1'b0;
`endif

  assign ps_tos       = empty_c ? '0 : mem[top_idx];
  assign ps_stk_lvl   = lvl;
  assign ps_stk_empty = empty_c;
  assign ps_stk_full  = full_c;
  assign ps_stk_ovf   = ovf_q;
  assign ps_stk_unf   = unf_q;
  assign ps_pop_vld   = pop_vld_q;

endmodule

// File: tb/tb_ps_pcstk_ctrl.sv
// Self-checking bench for ps_pcstk_ctrl: directed scenarios plus random traffic against a queue-based model.
// Honours PS_STK_TRAP_EN so the trap expectation tracks the build configuration.
module tb_ps_pcstk_ctrl;

  localparam int unsigned PC_WIDTH  = 16;
  localparam int unsigned STK_DEPTH = 8;
  localparam int unsigned LVL_W     = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                ps_pshstck;
  logic                ps_popstck;
  logic [PC_WIDTH-1:0] ps_pc;
  logic                ps_tos_wrt_en;
  logic [PC_WIDTH-1:0] ps_tos_wrt_data;
  logic                ps_stkclr;
  logic [PC_WIDTH-1:0] ps_tos;
  logic [LVL_W-1:0]    ps_stk_lvl;
  logic                ps_stk_empty;
  logic                ps_stk_full;
  logic                ps_stk_ovf;
  logic                ps_stk_unf;
  logic                ps_pop_vld;
  logic                ps_stk_trap;

  ps_pcstk_ctrl #(
    .PC_WIDTH (PC_WIDTH),
    .STK_DEPTH(STK_DEPTH),
    .LVL_W    (LVL_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ps_pshstck     (ps_pshstck),
    .ps_popstck     (ps_popstck),
    .ps_pc          (ps_pc),
    .ps_tos_wrt_en  (ps_tos_wrt_en),
    .ps_tos_wrt_data(ps_tos_wrt_data),
    .ps_stkclr      (ps_stkclr),
    .ps_tos         (ps_tos),
    .ps_stk_lvl     (ps_stk_lvl),
    .ps_stk_empty   (ps_stk_empty),
    .ps_stk_full    (ps_stk_full),
    .ps_stk_ovf     (ps_stk_ovf),
    .ps_stk_unf     (ps_stk_unf),
    .ps_pop_vld     (ps_pop_vld),
    .ps_stk_trap    (ps_stk_trap)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: the stack is a plain queue, top at the back
  logic [PC_WIDTH-1:0] m_stk[$];
  logic m_ovf, m_unf, m_pop_vld, m_trap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic psh, input logic pop, input logic wen,
                            input logic [PC_WIDTH-1:0] pc, input logic [PC_WIDTH-1:0] wd,
                            input logic clr, input logic rst);
    logic e_ovf, e_unf;
    int   sz;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    sz    = m_stk.size();
    if (rst) begin
      m_stk.delete();
      m_ovf = 0; m_unf = 0; m_pop_vld = 0; m_trap = 0;
      return;
    end
    m_pop_vld = 1'b0;
    if (psh && pop) begin
      if (sz > 0) begin
        m_stk[sz-1] = pc;
        m_pop_vld = 1'b1;
      end else begin
        m_stk.push_back(pc);
      end
    end else if (psh) begin
      if (sz < STK_DEPTH) m_stk.push_back(pc);
      else e_ovf = 1'b1;
    end else if (pop) begin
      if (sz > 0) begin
        void'(m_stk.pop_back());
        m_pop_vld = 1'b1;
      end else begin
        e_unf = 1'b1;
      end
    end else if (wen && sz > 0) begin
      m_stk[sz-1] = wd;
    end
    m_ovf = e_ovf | (m_ovf & ~clr);
    m_unf = e_unf | (m_unf & ~clr);
`ifdef PS_STK_TRAP_EN
    m_trap = e_ovf | e_unf;
`else
    m_trap = 1'b0;
`endif
  endtask

  task automatic compare_all();
    int sz;
    logic [PC_WIDTH-1:0] exp_tos;
    sz = m_stk.size();
    exp_tos = (sz == 0) ? '0 : m_stk[sz-1];
    check("lvl",     32'(ps_stk_lvl),   32'(sz));
    check("tos",     32'(ps_tos),       32'(exp_tos));
    check("empty",   32'(ps_stk_empty), 32'(sz == 0));
    check("full",    32'(ps_stk_full),  32'(sz == STK_DEPTH));
    check("ovf",     32'(ps_stk_ovf),   32'(m_ovf));
    check("unf",     32'(ps_stk_unf),   32'(m_unf));
    check("pop_vld", 32'(ps_pop_vld),   32'(m_pop_vld));
    check("trap",    32'(ps_stk_trap),  32'(m_trap));
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 ns later
  task automatic cyc(input logic psh, input logic pop, input logic wen,
                     input logic [PC_WIDTH-1:0] pc, input logic [PC_WIDTH-1:0] wd,
                     input logic clr, input logic rst);
    reset = rst; ps_pshstck = psh; ps_popstck = pop; ps_tos_wrt_en = wen;
    ps_pc = pc; ps_tos_wrt_data = wd; ps_stkclr = clr;
    @(posedge clk);
    model_step(psh, pop, wen, pc, wd, clr, rst);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic push(input logic [PC_WIDTH-1:0] v);
    cyc(1, 0, 0, v, '0, 0, 0);
  endtask

  task automatic pop1();
    cyc(0, 1, 0, '0, '0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, '0, '0, 0, 1);
  endtask

  logic exp_trap_bit;

  initial begin
`ifdef PS_STK_TRAP_EN
    exp_trap_bit = 1'b1;
`else
    exp_trap_bit = 1'b0;
`endif
    m_ovf = 0; m_unf = 0; m_pop_vld = 0; m_trap = 0;
    do_reset();
    do_reset();
    check("rst_lvl", 32'(ps_stk_lvl), 32'd0);
    check("rst_empty", 32'(ps_stk_empty), 32'd1);
    check("rst_tos", 32'(ps_tos), 32'd0);

    // Three pushes then a pop
    push(16'h0010); push(16'h0020); push(16'h0030);
    check("p3_lvl", 32'(ps_stk_lvl), 32'd3);
    check("p3_tos", 32'(ps_tos), 32'h0030);
    pop1();
    check("pop_vld", 32'(ps_pop_vld), 32'd1);
    check("pop_tos", 32'(ps_tos), 32'h0020);
    idle();
    check("pop_vld_off", 32'(ps_pop_vld), 32'd0);

    // Fill to full then overflow
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i * 16'h0101));
    check("full8", 32'(ps_stk_full), 32'd1);
    check("ovf8", 32'(ps_stk_ovf), 32'd0);
    push(16'hDEAD);
    check("ovf9", 32'(ps_stk_ovf), 32'd1);
    check("lvl9", 32'(ps_stk_lvl), 32'd8);
    check("tos9", 32'(ps_tos), 32'h0808);
    check("trap9", 32'(ps_stk_trap), 32'(exp_trap_bit));
    idle();
    check("trap9_off", 32'(ps_stk_trap), 32'd0);
    // Push+pop while full: overwrite, no new flag change beyond sticky
    cyc(1, 1, 0, 16'h0F0F, '0, 1, 0);
    check("pp_full_tos", 32'(ps_tos), 32'h0F0F);
    check("pp_full_ovf", 32'(ps_stk_ovf), 32'd0);

    // Underflow, sticky, clear; clear coinciding with new error keeps it set
    do_reset();
    pop1();
    check("unf", 32'(ps_stk_unf), 32'd1);
    check("unf_pv", 32'(ps_pop_vld), 32'd0);
    idle();
    check("unf_sticky", 32'(ps_stk_unf), 32'd1);
    cyc(0, 1, 0, '0, '0, 1, 0);
    check("unf_setwins", 32'(ps_stk_unf), 32'd1);
    cyc(0, 0, 0, '0, '0, 1, 0);
    check("unf_clr", 32'(ps_stk_unf), 32'd0);
    // Push+pop on empty acts as a push, no underflow
    cyc(1, 1, 0, 16'h4444, '0, 0, 0);
    check("pp_empty_lvl", 32'(ps_stk_lvl), 32'd1);
    check("pp_empty_unf", 32'(ps_stk_unf), 32'd0);

    // Push+pop at level 2 replaces top
    do_reset();
    push(16'h0111); push(16'h0AAA);
    cyc(1, 1, 0, 16'h0BBB, '0, 0, 0);
    check("pp_lvl", 32'(ps_stk_lvl), 32'd2);
    check("pp_tos", 32'(ps_tos), 32'h0BBB);
    check("pp_pv", 32'(ps_pop_vld), 32'd1);

    // ureg top-of-stack write, and push taking priority over it
    do_reset();
    push(16'h0001);
    cyc(0, 0, 1, '0, 16'h1234, 0, 0);
    check("uw_tos", 32'(ps_tos), 32'h1234);
    cyc(1, 0, 1, 16'h5678, 16'h9999, 0, 0);
    check("uw_psh_lvl", 32'(ps_stk_lvl), 32'd2);
    check("uw_psh_tos", 32'(ps_tos), 32'h5678);
    pop1();
    check("uw_below", 32'(ps_tos), 32'h1234);
    // Write on empty is ignored
    pop1();
    cyc(0, 0, 1, '0, 16'h7777, 0, 0);
    check("uw_empty", 32'(ps_tos), 32'd0);

    // Reset mid-sequence with a push pending
    for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
    pop1(); pop1(); pop1(); pop1(); pop1(); pop1();
    for (int i = 0; i < 5; i++) push(16'(16'h0200 + i));
    check("pre_rst_lvl", 32'(ps_stk_lvl), 32'd5);
    cyc(1, 0, 0, 16'hCAFE, '0, 0, 1);
    check("mid_rst_lvl", 32'(ps_stk_lvl), 32'd0);
    check("mid_rst_unf", 32'(ps_stk_unf), 32'd0);

    // Random traffic with shifting push/pop bias
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias, r;
      logic psh, pop, wen, clr, rst;
      bias = (i / 200) % 3;
      r = $urandom_range(0, 99);
      psh = (bias == 0) ? (r < 60) : (bias == 1) ? (r < 25) : (r < 45);
      r = $urandom_range(0, 99);
      pop = (bias == 0) ? (r < 20) : (bias == 1) ? (r < 60) : (r < 45);
      wen = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc(psh, pop, wen, 16'($urandom), 16'($urandom), clr, rst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps_pcstk_ctrl.md
PS_PCSTK_CTRL -- requirements
Module: ps_pcstk_ctrl

Interface
REQ-001 SHALL have parameter: PC_WIDTH, 16, width of stacked program-counter values.
REQ-002 SHALL have parameter: STK_DEPTH, 8, number of stack entries (power of two, 2..64).
REQ-003 SHALL have parameter: LVL_W, 4, level counter width (log2(STK_DEPTH)+1).
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: ps_pshstck  input  1  push request (call / PUSH STS).
REQ-007 SHALL have port: ps_popstck  input  1  pop request (return / POP STS).
REQ-008 SHALL have port: ps_pc  input  PC_WIDTH  value pushed.
REQ-009 SHALL have port: ps_tos_wrt_en  input  1  ureg write to top-of-stack (ureg address 5'b00100).
REQ-010 SHALL have port: ps_tos_wrt_data  input  PC_WIDTH  ureg write data.
REQ-011 SHALL have port: ps_stkclr  input  1  clears sticky overflow/underflow flags.
REQ-012 SHALL have port: ps_tos  output  PC_WIDTH  current top-of-stack value.
REQ-013 SHALL have port: ps_stk_lvl  output  LVL_W  number of valid entries.
REQ-014 SHALL have port: ps_stk_empty / ps_stk_full  output  1 each  level==0 / level==STK_DEPTH.
REQ-015 SHALL have port: ps_stk_ovf / ps_stk_unf  output  1 each  sticky overflow / underflow status.
REQ-016 SHALL have port: ps_pop_vld  output  1  registered; high one cycle after an accepted pop.
REQ-017 SHALL have port: ps_stk_trap  output  1  error trap pulse (see Configuration).

Function
REQ-018 SHALL accept a push when not full: entry[level] <= ps_pc, level+1; new value on ps_tos the next cycle.
REQ-019 SHALL, on push when full: leave storage and level unchanged, set ps_stk_ovf.
REQ-020 SHALL accept a pop when not empty: level-1, ps_pop_vld=1 next cycle; popped value is ps_tos in the request cycle.
REQ-021 SHALL, on pop when empty: leave level unchanged, set ps_stk_unf, ps_pop_vld stays 0.
REQ-022 SHALL, on simultaneous push+pop when non-empty: overwrite entry[level-1] with ps_pc, level unchanged, ps_pop_vld=1 next cycle, no flag set (including when full).
REQ-023 SHALL, on simultaneous push+pop when empty: perform push only; ps_stk_unf not set.
REQ-024 SHALL, on ps_tos_wrt_en with no push/pop and non-empty: overwrite entry[level-1]; empty: ignore, no flag.
REQ-025 SHALL give push/pop priority over ps_tos_wrt_en in the same cycle; the ureg write is dropped.
REQ-026 SHALL drive ps_tos combinationally from entry[level-1], all-zero when empty.
REQ-027 SHALL set status flags one cycle after the causing request; flags remain set until ps_stkclr or reset.
REQ-028 SHALL, when ps_stkclr coincides with a new error, leave the flag set (set wins).
REQ-029 SHALL never wrap level past 0 or STK_DEPTH.

Reset
REQ-030 SHALL, on reset, force level=0, ps_stk_empty=1, ps_stk_full=0, ps_stk_ovf=0, ps_stk_unf=0, ps_pop_vld=0, ps_stk_trap=0, ps_tos=0.
REQ-031 SHALL give reset priority over every request in the same cycle; entry contents need not be cleared.
REQ-032 SHALL ignore all requests while reset is high.

Configuration
REQ-033 SHALL, with PS_STK_TRAP_EN defined, pulse ps_stk_trap high for exactly one cycle, one cycle after each rejected push (overflow) or rejected pop (underflow), independent of sticky state.
REQ-034 SHALL, with PS_STK_TRAP_EN undefined, tie ps_stk_trap to 0 and include no trap logic; all other behaviour unchanged.

Verification
REQ-035 SHALL cover: reset, push 0x0010, 0x0020, 0x0030 -> level=3, ps_tos=0x0030; pop -> ps_pop_vld=1 next cycle, ps_tos=0x0020.
REQ-036 SHALL cover: 9 pushes with STK_DEPTH=8 -> ps_stk_full=1 after 8th, ps_stk_ovf=1 after 9th, level=8, ps_tos=8th value.
REQ-037 SHALL cover: pop when empty -> ps_stk_unf=1, level=0, ps_pop_vld=0; ps_stkclr -> ps_stk_unf=0 next cycle.
REQ-038 SHALL cover: level=2 top=0x0AAA, push+pop with ps_pc=0x0BBB -> level=2, ps_tos=0x0BBB, no flags.
REQ-039 SHALL cover: level=1, ps_tos_wrt_en with data 0x1234 -> ps_tos=0x1234; same with ps_pshstck high and ps_pc=0x5678 -> level=2, ps_tos=0x5678.
REQ-040 SHALL cover: reset asserted mid-sequence at level=5 with push pending -> level=0, all flags 0 next cycle; with PS_STK_TRAP_EN, overflow -> single-cycle ps_stk_trap pulse.
